// File: rtl/irda_link_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irda_link_arbiter_if
//  Description : Handshake bundle between the IrDA link arbiter, the two TX
//                requesters and the transmitter/receiver datapaths.
//                master = environment side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface irda_link_arbiter_if;
    logic [1:0] req;
    logic       start_bit;
    logic       trans_done;
    logic       rcv_done;
    logic [1:0] gnt;
    logic       ena_trans;
    logic       ena_rcv;
    logic       start_trans;
    logic       start_rcv;
    logic       rst_transmitter;
    logic       rst_receiver;
    logic       busy;
    logic       timeout;

    modport master (
        output req, start_bit, trans_done, rcv_done,
        input  gnt, ena_trans, ena_rcv, start_trans, start_rcv,
        input  rst_transmitter, rst_receiver, busy, timeout
    );

    modport slave (
        input  req, start_bit, trans_done, rcv_done,
        output gnt, ena_trans, ena_rcv, start_trans, start_rcv,
        output rst_transmitter, rst_receiver, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/irda_link_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irda_link_arbiter
//  Description : Half-duplex IrDA link arbiter. Grants the transmitter to one
//                of two requesters (round-robin) or hands the line to the
//                receiver when a start bit is seen, then enforces a guard gap.
//                Optional session watchdog: define IRDA_ARB_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module irda_link_arbiter #(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic          clk,
    input  wire logic          rst,
    irda_link_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TX    = 3'd1,
        S_RX    = 3'd2,
`ifdef IRDA_ARB_WATCHDOG_EN
        S_ABORT = 3'd3,
`endif
        S_GUARD = 3'd4
    } state_t;

    // Guard counter loads N-1 and counts down, giving exactly N guard cycles.
    localparam logic [7:0] c_guard_last = 8'(GUARD_CYCLES - 1);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("irda_link_arbiter: GUARD_CYCLES or TIMEOUT_CYCLES out of range");
    end

    state_t     r_state;
    logic       r_rr;
    logic [7:0] r_guard_cnt;
    logic [1:0] r_gnt;
    logic       r_ena_trans;
    logic       r_ena_rcv;
    logic       r_start_trans;
    logic       r_start_rcv;
    logic       r_rst_transmitter;
    logic       r_rst_receiver;
    logic       r_busy;
    logic       w_win;

`ifdef IRDA_ARB_WATCHDOG_EN
    // Counter holds the number of completed session cycles; the last allowed
    // cycle is the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wdog;
    logic        r_timeout;
`endif

    // Winner selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        w_win = r_rr;
        if (bus.req == 2'b01)      w_win = 1'b0;
        else if (bus.req == 2'b10) w_win = 1'b1;
    end

    // Single state machine with registered (Moore) outputs; each output is
    // loaded together with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_rr              <= 1'b0;
            r_guard_cnt       <= 8'd0;
            r_gnt             <= 2'b00;
            r_ena_trans       <= 1'b0;
            r_ena_rcv         <= 1'b0;
            r_start_trans     <= 1'b0;
            r_start_rcv       <= 1'b0;
            r_rst_transmitter <= 1'b1;
            r_rst_receiver    <= 1'b1;
            r_busy            <= 1'b0;
`ifdef IRDA_ARB_WATCHDOG_EN
            r_wdog            <= 16'd0;
            r_timeout         <= 1'b0;
`endif
        end else begin
            // Pulses and datapath resets default low every cycle.
            r_start_trans     <= 1'b0;
            r_start_rcv       <= 1'b0;
            r_rst_transmitter <= 1'b0;
            r_rst_receiver    <= 1'b0;
`ifdef IRDA_ARB_WATCHDOG_EN
            r_timeout         <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // Incoming frame owns the half-duplex line before any TX.
                    if (!bus.start_bit) begin
                        r_state     <= S_RX;
                        r_ena_rcv   <= 1'b1;
                        r_start_rcv <= 1'b1;
                        r_busy      <= 1'b1;
`ifdef IRDA_ARB_WATCHDOG_EN
                        r_wdog      <= 16'd0;
`endif
                    end else if (bus.req != 2'b00) begin
                        r_state       <= S_TX;
                        r_gnt         <= w_win ? 2'b10 : 2'b01;
                        r_rr          <= ~w_win;
                        r_ena_trans   <= 1'b1;
                        r_start_trans <= 1'b1;
                        r_busy        <= 1'b1;
`ifdef IRDA_ARB_WATCHDOG_EN
                        r_wdog        <= 16'd0;
`endif
                    end
                end
                S_TX: begin
                    if (bus.trans_done) begin
                        r_state     <= S_GUARD;
                        r_guard_cnt <= c_guard_last;
                        r_gnt       <= 2'b00;
                        r_ena_trans <= 1'b0;
`ifdef IRDA_ARB_WATCHDOG_EN
                    end else if (r_wdog == c_timeout_last) begin
                        r_state           <= S_ABORT;
                        r_timeout         <= 1'b1;
                        r_rst_transmitter <= 1'b1;
                        r_gnt             <= 2'b00;
                        r_ena_trans       <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
`endif
                    end
                end
                S_RX: begin
                    if (bus.rcv_done) begin
                        r_state     <= S_GUARD;
                        r_guard_cnt <= c_guard_last;
                        r_ena_rcv   <= 1'b0;
`ifdef IRDA_ARB_WATCHDOG_EN
                    end else if (r_wdog == c_timeout_last) begin
                        r_state        <= S_ABORT;
                        r_timeout      <= 1'b1;
                        r_rst_receiver <= 1'b1;
                        r_ena_rcv      <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
`endif
                    end
                end
`ifdef IRDA_ARB_WATCHDOG_EN
                S_ABORT: begin
                    r_state     <= S_GUARD;
                    r_guard_cnt <= c_guard_last;
                end
`endif
                S_GUARD: begin
                    if (r_guard_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gnt       <= 2'b00;
                    r_ena_trans <= 1'b0;
                    r_ena_rcv   <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt             = r_gnt;
    assign bus.ena_trans       = r_ena_trans;
    assign bus.ena_rcv         = r_ena_rcv;
    assign bus.start_trans     = r_start_trans;
    assign bus.start_rcv       = r_start_rcv;
    assign bus.rst_transmitter = r_rst_transmitter;
    assign bus.rst_receiver    = r_rst_receiver;
    assign bus.busy            = r_busy;
`ifdef IRDA_ARB_WATCHDOG_EN
    assign bus.timeout         = r_timeout;
`else
    assign bus.timeout         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/irda_link_arbiter.md
IRDA_LINK_ARBITER -- requirements
Module: irda_link_arbiter

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 4: idle turnaround cycles after each TX/RX; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit in cycles per TX/RX session; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  2  TX requests from requester 0/1, level, active-high.
REQ-006 SHALL have port start_bit  input  1  IR line start detect, active-low.
REQ-007 SHALL have ports trans_done, rcv_done  input  1 each  session-complete pulses from transmitter/receiver.
REQ-008 SHALL have port gnt  output  2  one-hot grant; held for the whole TX session.
REQ-009 SHALL have ports ena_trans, ena_rcv  output  1 each  datapath enables.
REQ-010 SHALL have ports start_trans, start_rcv  output  1 each  one-cycle session-start pulses.
REQ-011 SHALL have ports rst_transmitter, rst_receiver  output  1 each  datapath resets, active-high.
REQ-012 SHALL have ports busy (state not IDLE) and timeout (one-cycle abort pulse)  output  1 each.

Function
REQ-013 SHALL have states IDLE, TX, RX, ABORT, GUARD; all outputs registered (Moore), valid the cycle after the state is entered.
REQ-014 IDLE: start_bit==0 SHALL move to RX, taking priority over any req in the same cycle (half-duplex channel).
REQ-015 IDLE with start_bit==1 and req!=0 SHALL move to TX, granting per round-robin pointer rr.
REQ-016 Arbitration: with one req bit set, that requester SHALL win; with both set, requester rr SHALL win; rr SHALL become the loser's index on each grant.
REQ-017 First TX cycle: start_trans=1, ena_trans=1, gnt set; then ena_trans and gnt held, start_trans=0.
REQ-018 First RX cycle: start_rcv=1, ena_rcv=1; then ena_rcv held, start_rcv=0.
REQ-019 TX SHALL sample trans_done from its first cycle on; trans_done=1 moves to GUARD. RX likewise with rcv_done. trans_done in RX, rcv_done in TX, and either in IDLE/GUARD SHALL be ignored.
REQ-020 req deassertion during TX SHALL be ignored; the session runs until trans_done or abort.
REQ-021 GUARD: enables, gnt and start pulses 0; GUARD_CYCLES cycles are spent in GUARD, then IDLE; start_bit and req ignored.
REQ-022 Latency: request seen in IDLE at cycle N gives start_trans at N+1; next grant no earlier than GUARD_CYCLES+1 cycles after trans_done is sampled.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, rr=0, counters 0, gnt=0, all enables/start pulses/busy/timeout 0, rst_transmitter=rst_receiver=1.
REQ-024 rst_transmitter/rst_receiver SHALL stay 1 while rst=1 and return to 0 on the first edge with rst=0; rst mid-session SHALL abort without timeout pulse.

Configuration
REQ-025 Macro IRDA_ARB_WATCHDOG_EN defined: a session counter SHALL clear on entering TX/RX and increment each TX/RX cycle; reaching TIMEOUT_CYCLES without done SHALL enter ABORT.
REQ-026 ABORT (one cycle): timeout=1; rst_transmitter=1 if aborting TX, rst_receiver=1 if aborting RX; enables and gnt 0; then GUARD.
REQ-027 Done sampled in the cycle the counter reaches the limit SHALL win: go to GUARD, no abort.
REQ-028 Macro undefined: no counter or ABORT state, timeout tied 0, TX/RX wait indefinitely for done.

Verification (GUARD_CYCLES=4, TIMEOUT_CYCLES=16, watchdog enabled)
REQ-029 req=2'b01 at cycle 10 -> start_trans=1 and gnt=01 at 11; trans_done at 20 -> GUARD 21-24, IDLE 25.
REQ-030 req=2'b11 held after reset -> gnt=01 first session, gnt=10 second, gnt=01 third.
REQ-031 start_bit=0 and req=2'b10 together in IDLE -> start_rcv=1, gnt=00; TX granted only after rcv_done plus guard.
REQ-032 TX with no trans_done -> ABORT after 16 TX cycles: timeout=1, rst_transmitter=1 for one cycle, then 4 GUARD cycles.
REQ-033 trans_done on the 16th TX cycle -> no timeout pulse, normal GUARD.
REQ-034 rst=1 for 2 cycles mid-RX -> ena_rcv=0, rst_transmitter=rst_receiver=1 during rst, IDLE with rr=0 afterwards.
